// File: rtl/str_byte_serializer.sv
// Right-justified packed string word to byte stream, top valid char first; first byte 1 cycle after accept,
// holds under out_ready stall, zero-bubble between words. Optional NUL skipping via STR_SER_NUL_SKIP_EN.
module str_byte_serializer #(
   parameter int NBYTES = 4,
   parameter int LEN_W  = $clog2(NBYTES + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [NBYTES*8-1:0]   in_data,
   input  logic [LEN_W-1:0]      in_len,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [7:0]            out_byte,
   output logic                  out_last,
   output logic                  busy,
   output logic                  err_len
);

   localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                state_q;
   logic                  out_valid_q;
   logic [7:0]            out_byte_q;
   logic                  out_last_q;
   logic                  err_len_q;
   logic [NBYTES-1:0]     rem_q;
   logic [NBYTES*8-1:0]   data_q;

   function automatic logic [NBYTES-1:0] len_mask(input logic [LEN_W-1:0] n);
      logic [NBYTES-1:0] m;
      for (int k = 0; k < NBYTES; k++) m[k] = (LEN_W'(k) < n);
      return m;
   endfunction

   function automatic logic [NBYTES-1:0] below_idx(input logic [IDX_W-1:0] i);
      logic [NBYTES-1:0] m;
      for (int k = 0; k < NBYTES; k++) m[k] = (IDX_W'(k) < i);
      return m;
   endfunction

   function automatic logic [IDX_W-1:0] top_bit(input logic [NBYTES-1:0] m);
      logic [IDX_W-1:0] h;
      h = '0;
      for (int k = 0; k < NBYTES; k++) if (m[k]) h = IDX_W'(k);
      return h;
   endfunction

   function automatic logic [7:0] byte_at(input logic [NBYTES*8-1:0] d, input logic [IDX_W-1:0] i);
      logic [7:0] b;
      b = '0;
      for (int k = 0; k < NBYTES; k++) if (IDX_W'(k) == i) b = d[8*k +: 8];
      return b;
   endfunction

   // Characters eligible for emission; rem_q holds the eligible positions still below the current byte.
   logic [NBYTES-1:0] char_ok;
`ifdef STR_SER_NUL_SKIP_EN
   always_comb begin
      char_ok = '0;
      for (int k = 0; k < NBYTES; k++) char_ok[k] = |in_data[8*k +: 8];
   end
`else
   assign char_ok = '1;
`endif

   logic                  accept;
   logic                  load;
   logic                  too_long;
   logic [LEN_W-1:0]      eff_len;
   logic [NBYTES-1:0]     acc_mask;
   logic [NBYTES-1:0]     acc_rem;
   logic [NBYTES-1:0]     adv_rem;
   logic [IDX_W-1:0]      acc_idx;
   logic [IDX_W-1:0]      adv_idx;

   assign too_long = in_len > LEN_W'(NBYTES);
   assign eff_len  = too_long ? LEN_W'(NBYTES) : in_len;
   assign acc_mask = len_mask(eff_len) & char_ok;
   assign acc_idx  = top_bit(acc_mask);
   assign acc_rem  = acc_mask & below_idx(acc_idx);
   assign adv_idx  = top_bit(rem_q);
   assign adv_rem  = rem_q & below_idx(adv_idx);

   assign in_ready = rst_n && ((state_q == IDLE) || (out_valid_q && out_last_q && out_ready));
   assign accept   = in_valid && in_ready;
   // Only reachable from IDLE or on the final handshake, so a load also covers back-to-back words.
   assign load     = accept && (|acc_mask);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_byte_q  <= 8'h00;
         out_last_q  <= 1'b0;
         err_len_q   <= 1'b0;
         rem_q       <= '0;
         data_q      <= '0;
      end else begin
         err_len_q <= accept && too_long;
         if (accept) data_q <= in_data;
         if (load) begin
            state_q     <= SHIFT;
            out_valid_q <= 1'b1;
            out_byte_q  <= byte_at(in_data, acc_idx);
            out_last_q  <= (acc_rem == '0);
            rem_q       <= acc_rem;
         end else if (state_q == SHIFT && out_ready) begin
            if (!out_last_q) begin
               out_byte_q <= byte_at(data_q, adv_idx);
               out_last_q <= (adv_rem == '0);
               rem_q      <= adv_rem;
            end else begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               out_last_q  <= 1'b0;
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_byte  = out_byte_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q == SHIFT);
   assign err_len   = err_len_q;

endmodule

// File: tb/tb_str_byte_serializer.sv
// Directed bench for str_byte_serializer (NBYTES=4); inputs driven and outputs checked just after each falling edge.
module tb_str_byte_serializer;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [2:0]  in_len;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_byte;
   logic        out_last;
   logic        busy;
   logic        err_len;

   int n_chk  = 0;
   int n_fail = 0;

   str_byte_serializer #(.NBYTES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_len    (in_len),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_byte  (out_byte),
      .out_last  (out_last),
      .busy      (busy),
      .err_len   (err_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic beat(input string tag, input logic [7:0] b, input logic l);
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_byte"}, out_byte, b);
      chk({tag, "_last"}, out_last, l);
      chk({tag, "_busy"}, busy, 1);
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_last"}, out_last, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_in_ready"}, in_ready, 1);
   endtask

   initial begin
      logic [7:0] hell [4];
      logic [7:0] long7 [4];
      hell  = '{8'h68, 8'h65, 8'h6C, 8'h6C};
      long7 = '{8'h31, 8'h32, 8'h33, 8'h34};

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_len = '0; out_ready = 1'b0;
      @(negedge clk); @(negedge clk); #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_byte", out_byte, 0);
      chk("rst_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_len, 0);
      chk("rst_in_ready", in_ready, 0);
      @(negedge clk); rst_n = 1'b1; #1;
      idle_chk("post_rst");

      // Single 4-char word, consumer always ready
      @(negedge clk); in_valid = 1; in_data = 32'h68656C6C; in_len = 4; out_ready = 1; #1;
      chk("t1_accept_rdy", in_ready, 1);
      @(negedge clk); in_valid = 0; #1;
      chk("t1_err", err_len, 0);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin @(negedge clk); #1; end
         beat("t1_beat", hell[i], i == 3);
         chk("t1_in_ready", in_ready, (i == 3) ? 1 : 0);
      end
      @(negedge clk); #1;
      idle_chk("t1_done");

      // Short word with stall; junk offered while in_ready is low must be ignored
      @(negedge clk); in_valid = 1; in_data = 32'h0000_4869; in_len = 2; out_ready = 1; #1;
      @(negedge clk); in_data = 32'hFFFF_FFFF; in_len = 4; out_ready = 0; #1;
      beat("t2_stall0", 8'h48, 0);
      chk("t2_stall0_rdy", in_ready, 0);
      @(negedge clk); out_ready = 0; #1;
      beat("t2_stall1", 8'h48, 0);
      chk("t2_stall1_rdy", in_ready, 0);
      @(negedge clk); out_ready = 1; #1;
      beat("t2_go", 8'h48, 0);
      chk("t2_go_rdy", in_ready, 0);
      @(negedge clk); in_valid = 0; #1;
      beat("t2_last", 8'h69, 1);
      chk("t2_last_rdy", in_ready, 1);
      @(negedge clk); #1;
      idle_chk("t2_done");

      // Back-to-back words, no bubble
      @(negedge clk); in_valid = 1; in_data = 32'h0000_4142; in_len = 2; #1;
      @(negedge clk); in_valid = 0; #1;
      beat("t3_a0", 8'h41, 0);
      @(negedge clk); in_valid = 1; in_data = 32'h0000_0043; in_len = 1; #1;
      beat("t3_a1", 8'h42, 1);
      chk("t3_a1_rdy", in_ready, 1);
      @(negedge clk); in_valid = 0; #1;
      beat("t3_b0", 8'h43, 1);
      @(negedge clk); #1;
      idle_chk("t3_done");

      // Zero length: accepted and dropped
      @(negedge clk); in_valid = 1; in_data = 32'h1122_3344; in_len = 0; #1;
      chk("t4_len0_rdy", in_ready, 1);
      @(negedge clk); in_valid = 0; #1;
      idle_chk("t4_len0");
      chk("t4_len0_err", err_len, 0);

      // Over-length: clamps to 4 bytes and pulses err_len once
      @(negedge clk); in_valid = 1; in_data = 32'h3132_3334; in_len = 7; #1;
      @(negedge clk); in_valid = 0; #1;
      chk("t4_err_pulse", err_len, 1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            @(negedge clk); #1;
            chk("t4_err_clear", err_len, 0);
         end
         beat("t4_beat", long7[i], i == 3);
      end
      @(negedge clk); #1;
      idle_chk("t4_done");

      // Reset mid-word, then a fresh word
      @(negedge clk); in_valid = 1; in_data = 32'h4142_4344; in_len = 4; #1;
      @(negedge clk); in_valid = 0; #1;
      beat("t5_b0", 8'h41, 0);
      @(negedge clk); #1;
      beat("t5_b1", 8'h42, 0);
      @(negedge clk); rst_n = 0; #1;
      chk("t5_rst_rdy", in_ready, 0);
      @(negedge clk); #1;
      chk("t5_rst_valid", out_valid, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_byte", out_byte, 0);
      chk("t5_rst_last", out_last, 0);
      @(negedge clk); rst_n = 1; in_valid = 1; in_data = 32'h0000_5A59; in_len = 2; #1;
      @(negedge clk); in_valid = 0; #1;
      beat("t5_n0", 8'h5A, 0);
      @(negedge clk); #1;
      beat("t5_n1", 8'h59, 1);
      @(negedge clk); #1;
      idle_chk("t5_done");

`ifdef STR_SER_NUL_SKIP_EN
      @(negedge clk); in_valid = 1; in_data = 32'h4800_6900; in_len = 4; #1;
      @(negedge clk); in_valid = 0; #1;
      beat("t6_n0", 8'h48, 0);
      @(negedge clk); #1;
      beat("t6_n1", 8'h69, 1);
      @(negedge clk); #1;
      idle_chk("t6_done");
      @(negedge clk); in_valid = 1; in_data = 32'h0; in_len = 4; #1;
      @(negedge clk); in_valid = 0; #1;
      idle_chk("t6_allnul");
`else
      @(negedge clk); in_valid = 1; in_data = 32'h0000_4100; in_len = 2; #1;
      @(negedge clk); in_valid = 0; #1;
      beat("t6_n0", 8'h41, 0);
      @(negedge clk); #1;
      beat("t6_n1", 8'h00, 1);
      @(negedge clk); #1;
      idle_chk("t6_done");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
